muldiv_sequencer: RTL

- Iterative signed multiply/divide engine. It replaces the single-cycle MUL/DIV paths feeding ZHI/ZLO.
- The control unit pulses Start with the operation; operand A comes from Y and operand B from the bus.
- The block runs one radix-2 Booth step or one restoring-division step per clock, then presents a 64-bit {HI,LO} result for ZHIin/ZLOin capture.
- The control unit holds its T-state while Busy is high.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/div_step.sv | 38 +++
 rtl/muldiv_sequencer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide
// sequencer.
//   state_t      - sequencer states (IDLE, RUN, FIX, DONE)
//   OP_MUL/DIV   - encoding of the op_i request bit
//   WIDTH_DEF    - default operand width
//   CNT_W_DEF    - default iteration counter width (2**CNT_W_DEF > WIDTH_DEF)
//   DIV_ZERO_LO  - LO half reported for a divide by zero at the default width
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [WIDTH_DEF-1:0] DIV_ZERO_LO = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/div_step.sv
// div_step: one iteration of unsigned restoring division (combinational).
//   rem_i  - partial remainder, always < dvs_i
//   quo_i  - dividend bits not yet consumed (MSB first), collecting quotient
//            bits at the LSB end
//   dvs_i  - divisor magnitude (non-zero)
//   rem_o  - next partial remainder
//   quo_o  - quotient/dividend register shifted left with the new bit
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted = {rem_i, quo_i[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_i};
    // Because rem_i < dvs_i, shifted < 2*dvs_i: a non-negative difference is
    // below 2**WIDTH, a negative one wraps above it, so the top bit is the
    // borrow.
    fits    = ~diff[WIDTH];
    if (fits) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative signed multiply (radix-2 Booth) / divide
// (restoring, truncating toward zero) producing a 2*WIDTH {HI,LO} result.
//   clk_i        - clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   start_i      - request, sampled only in IDLE
//   op_i         - 0 = MUL, 1 = DIV, captured with start_i
//   abort_i      - synchronous cancel, returns to IDLE, keeps result/div_zero
//   operand_a_i  - multiplicand / dividend, captured with start_i
//   operand_b_i  - multiplier / divisor, captured with start_i
//   busy_o       - high in RUN and FIX
//   done_o       - one-cycle pulse in DONE
//   div_zero_o   - DIV with divisor 0; cleared by the next accepted start
//   result_o     - [2W-1:W] HI (product high / remainder),
//                  [W-1:0]  LO (product low / quotient)
//   dbg_state_o  - current sequencer state
//
// Handshake: start_i is a request accepted only when the block is in IDLE
// and abort_i is low; there is no ready output, the requester watches busy_o
// and done_o. Requests while busy or in DONE are dropped, not queued.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               op_i,
  input  logic               abort_i,
  input  logic [WIDTH-1:0]   operand_a_i,
  input  logic [WIDTH-1:0]   operand_b_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               div_zero_o,
  output logic [2*WIDTH-1:0] result_o,
  output state_t             dbg_state_o
);

  localparam logic [WIDTH-1:0] LO_ONES = '1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 op_q, op_d;
  // Multiplicand for MUL, divisor magnitude for DIV.
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  // Booth register: {accumulator, multiplier, q(-1)}.
  logic [2*WIDTH:0]     booth_q, booth_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 div_zero_q, div_zero_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH-1:0]     acc, mplr;
  logic [WIDTH:0]       booth_sum;
  logic [2*WIDTH:0]     booth_next;
  logic [WIDTH-1:0]     rem_step, quo_step;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (opnd_q),
    .rem_o (rem_step),
    .quo_o (quo_step)
  );

  always_comb begin
    a_mag = operand_a_i[WIDTH-1] ? -operand_a_i : operand_a_i;
    b_mag = operand_b_i[WIDTH-1] ? -operand_b_i : operand_b_i;
  end

  // Booth step. The add/subtract is done one bit wider than the accumulator
  // so that the most negative multiplicand cannot overflow; that extra bit
  // becomes the new accumulator sign after the arithmetic shift.
  always_comb begin
    acc  = booth_q[2*WIDTH:WIDTH+1];
    mplr = booth_q[WIDTH:1];
    unique case ({mplr[0], booth_q[0]})
      2'b01:   booth_sum = {acc[WIDTH-1], acc} + {opnd_q[WIDTH-1], opnd_q};
      2'b10:   booth_sum = {acc[WIDTH-1], acc} - {opnd_q[WIDTH-1], opnd_q};
      default: booth_sum = {acc[WIDTH-1], acc};
    endcase
    booth_next = {booth_sum, mplr};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    opnd_d     = opnd_q;
    booth_d    = booth_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    div_zero_d = div_zero_q;

    if (abort_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            op_d       = op_i;
            div_zero_d = 1'b0;
            if (op_i == OP_DIV && operand_b_i == '0) begin
              result_d   = {operand_a_i, LO_ONES};
              div_zero_d = 1'b1;
              state_d    = DONE;
            end else begin
              cnt_d     = CNT_W'(WIDTH);
              opnd_d    = (op_i == OP_DIV) ? b_mag : operand_a_i;
              booth_d   = {{WIDTH{1'b0}}, operand_b_i, 1'b0};
              rem_d     = '0;
              quo_d     = a_mag;
              neg_quo_d = operand_a_i[WIDTH-1] ^ operand_b_i[WIDTH-1];
              neg_rem_d = operand_a_i[WIDTH-1];
              state_d   = RUN;
            end
          end
        end
        RUN: begin
          if (op_q == OP_MUL) begin
            booth_d = booth_next;
          end else begin
            rem_d = rem_step;
            quo_d = quo_step;
          end
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          if (op_q == OP_MUL) begin
            result_d = booth_q[2*WIDTH:1];
          end else begin
            result_d = {neg_rem_q ? -rem_q : rem_q,
                        neg_quo_q ? -quo_q : quo_q};
          end
          state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      op_q       <= 1'b0;
      opnd_q     <= '0;
      booth_q    <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      opnd_q     <= opnd_d;
      booth_q    <= booth_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy_o      = (state_q == RUN) || (state_q == FIX);
  assign done_o      = (state_q == DONE);
  assign div_zero_o  = div_zero_q;
  assign result_o    = result_q;
  assign dbg_state_o = state_q;

endmodule
